// File: rtl/global_mem_responder_bridge.sv
// rtl/global_mem_responder_bridge.sv - wide AXI responder fanning out to lane-interleaved cluster memories
//
// Purpose: presents NrClusters cluster memory ports as one wide AXI slave. AR/AW are
// broadcast to every cluster, W beats are split into per-cluster lanes, and per-cluster
// R beats and B responses are merged back into single wide responses.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   axi_req_i/axi_resp_o  system-side wide AXI slave
//   cluster_axi_req_o     per-cluster AXI requests (lane i = data bits [i*CW +: CW])
//   cluster_axi_resp_i    per-cluster AXI responses

package global_mem_responder_bridge_pkg;
    localparam int unsigned IdWidth          = 4;
    localparam int unsigned AddrWidth        = 64;
    localparam int unsigned DataWidth        = 256;
    localparam int unsigned ClusterDataWidth = 64;
    localparam int unsigned UserWidth        = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [ClusterDataWidth-1:0]   data;
        logic [ClusterDataWidth/8-1:0] strb;
        logic                          last;
        logic [UserWidth-1:0]          user;
    } cw_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]          id;
        logic [ClusterDataWidth-1:0] data;
        logic [1:0]                  resp;
        logic                        last;
        logic [UserWidth-1:0]        user;
    } cr_chan_t;

    typedef struct packed {
        ax_chan_t aw; logic aw_valid;
        w_chan_t  w;  logic w_valid;
        logic     b_ready;
        ax_chan_t ar; logic ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        logic b_valid;  b_chan_t b;
        logic r_valid;  r_chan_t r;
    } axi_resp_t;

    typedef struct packed {
        ax_chan_t aw; logic aw_valid;
        cw_chan_t w;  logic w_valid;
        logic     b_ready;
        ax_chan_t ar; logic ar_valid;
        logic     r_ready;
    } cluster_axi_req_t;

    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        logic b_valid;  b_chan_t b;
        logic r_valid;  cr_chan_t r;
    } cluster_axi_resp_t;
endpackage

module global_mem_responder_bridge #(
    parameter int unsigned NrClusters          = 4,
    parameter int unsigned AxiDataWidth        = 256,
    parameter int unsigned ClusterAxiDataWidth = 64,
    parameter int unsigned AxiAddrWidth        = 64,
    parameter type axi_req_t          = global_mem_responder_bridge_pkg::axi_req_t,
    parameter type axi_resp_t         = global_mem_responder_bridge_pkg::axi_resp_t,
    parameter type cluster_axi_req_t  = global_mem_responder_bridge_pkg::cluster_axi_req_t,
    parameter type cluster_axi_resp_t = global_mem_responder_bridge_pkg::cluster_axi_resp_t,
    parameter type r_chan_t           = global_mem_responder_bridge_pkg::r_chan_t,
    parameter type b_chan_t           = global_mem_responder_bridge_pkg::b_chan_t
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  axi_req_t          axi_req_i,
    output axi_resp_t         axi_resp_o,
    output cluster_axi_req_t  cluster_axi_req_o  [NrClusters],
    input  cluster_axi_resp_t cluster_axi_resp_i [NrClusters]
);
    localparam int unsigned CW          = ClusterAxiDataWidth;
    localparam int unsigned CS          = ClusterAxiDataWidth / 8;
    localparam logic [2:0]  ClusterSize = 3'($clog2(CS));

    if (AxiDataWidth != NrClusters * ClusterAxiDataWidth) begin : g_width_check
        $error("AxiDataWidth must equal NrClusters*ClusterAxiDataWidth");
    end
    if ($bits(axi_req_i.ar.addr) != AxiAddrWidth) begin : g_addr_check
        $error("axi_req_t address width does not match AxiAddrWidth");
    end

    logic [NrClusters-1:0] ar_mask_q, aw_mask_q, w_mask_q, b_mask_q, b_mask_d, b_acc;
    logic [NrClusters-1:0] c_ar_ready, c_aw_ready, c_w_ready, c_r_valid, c_b_valid;
    logic [NrClusters-1:0] c_ar_valid, c_aw_valid, c_w_valid;
    logic [2:0]            aw_pending_q;
    logic                  aw_full, aw_pend_nz, ar_ready, aw_ready, w_ready;
    logic                  ar_hs, aw_hs, w_hs, w_last_hs, r_load, b_pop;
    logic                  r_valid_q, b_valid_q, last_mismatch, unused_cluster_fields;
    logic [1:0]            r_resp_max;
    r_chan_t               r_q, r_d;
    b_chan_t               b_q, b_d;

    assign aw_full    = (aw_pending_q == 3'd4);
    assign aw_pend_nz = (aw_pending_q != 3'd0);

    always_comb begin
        c_ar_ready = '0; c_aw_ready = '0; c_w_ready = '0; c_r_valid = '0; c_b_valid = '0;
        c_ar_valid = '0; c_aw_valid = '0; c_w_valid = '0;
        for (int unsigned i = 0; i < NrClusters; i++) begin
            c_ar_ready[i] = cluster_axi_resp_i[i].ar_ready;
            c_aw_ready[i] = cluster_axi_resp_i[i].aw_ready;
            c_w_ready[i]  = cluster_axi_resp_i[i].w_ready;
            c_r_valid[i]  = cluster_axi_resp_i[i].r_valid;
            c_b_valid[i]  = cluster_axi_resp_i[i].b_valid;
            c_ar_valid[i] = axi_req_i.ar_valid & ~ar_mask_q[i];
            // A full AW counter also withholds AW from clusters so W ordering stays simple.
            c_aw_valid[i] = axi_req_i.aw_valid & ~aw_full & ~aw_mask_q[i];
            c_w_valid[i]  = axi_req_i.w_valid & aw_pend_nz & ~w_mask_q[i];
        end
    end

    assign ar_ready  = &(ar_mask_q | c_ar_ready);
    assign aw_ready  = ~aw_full & (&(aw_mask_q | c_aw_ready));
    assign w_ready   = aw_pend_nz & (&(w_mask_q | c_w_ready));
    assign ar_hs     = axi_req_i.ar_valid & ar_ready;
    assign aw_hs     = axi_req_i.aw_valid & aw_ready;
    assign w_hs      = axi_req_i.w_valid & w_ready;
    assign w_last_hs = w_hs & axi_req_i.w.last;
    // Lock-step pop: clusters are only acknowledged when every lane has its beat.
    assign r_load    = (&c_r_valid) & (~r_valid_q | axi_req_i.r_ready);
    assign b_pop     = b_valid_q & axi_req_i.b_ready;
    assign b_acc     = c_b_valid & ~b_mask_q;
    assign b_mask_d  = b_mask_q | b_acc;

    always_comb begin
        r_d           = r_q;
        r_resp_max    = '0;
        last_mismatch = 1'b0;
        for (int unsigned i = 0; i < NrClusters; i++) begin
            r_d.data[i*CW +: CW] = cluster_axi_resp_i[i].r.data;
            if (cluster_axi_resp_i[i].r.resp > r_resp_max) r_resp_max = cluster_axi_resp_i[i].r.resp;
            if (cluster_axi_resp_i[i].r.last != cluster_axi_resp_i[0].r.last) last_mismatch = 1'b1;
        end
        r_d.id   = cluster_axi_resp_i[0].r.id;
        r_d.last = cluster_axi_resp_i[0].r.last;
        r_d.user = cluster_axi_resp_i[0].r.user;
        r_d.resp = r_resp_max;
    end

    always_comb begin
        b_d = b_q;
        if (b_acc[0]) b_d.id = cluster_axi_resp_i[0].b.id;
        for (int unsigned i = 0; i < NrClusters; i++) begin
            if (b_acc[i] && (cluster_axi_resp_i[i].b.resp > b_d.resp)) b_d.resp = cluster_axi_resp_i[i].b.resp;
        end
    end

    always_comb begin
        unused_cluster_fields = 1'b0;
        for (int unsigned i = 1; i < NrClusters; i++) begin
            unused_cluster_fields = unused_cluster_fields ^ (^{cluster_axi_resp_i[i].r.id,
                cluster_axi_resp_i[i].r.user, cluster_axi_resp_i[i].b.id});
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_mask_q    <= '0;
            aw_mask_q    <= '0;
            w_mask_q     <= '0;
            b_mask_q     <= '0;
            aw_pending_q <= '0;
            r_valid_q    <= 1'b0;
            r_q          <= '0;
            b_valid_q    <= 1'b0;
            b_q          <= '0;
        end else begin
            ar_mask_q <= ar_hs ? '0 : (ar_mask_q | (c_ar_valid & c_ar_ready));
            aw_mask_q <= aw_hs ? '0 : (aw_mask_q | (c_aw_valid & c_aw_ready));
            w_mask_q  <= w_hs  ? '0 : (w_mask_q  | (c_w_valid  & c_w_ready));
            unique case ({aw_hs, w_last_hs})
                2'b10:   aw_pending_q <= aw_pending_q + 3'd1;
                2'b01:   aw_pending_q <= aw_pending_q - 3'd1;
                default: aw_pending_q <= aw_pending_q;
            endcase
            if (r_load) begin
                r_q       <= r_d;
                r_valid_q <= 1'b1;
            end else if (axi_req_i.r_ready) begin
                r_valid_q <= 1'b0;
            end
            // While b_valid is up the mask is full, so no cluster B can land in the pop cycle.
            if (b_pop) begin
                b_mask_q  <= '0;
                b_q.resp  <= '0;
                b_valid_q <= 1'b0;
            end else begin
                b_mask_q  <= b_mask_d;
                b_q       <= b_d;
                b_valid_q <= &b_mask_d;
            end
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.r_valid  = r_valid_q;
        axi_resp_o.r        = r_q;
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.b        = b_q;
        for (int unsigned i = 0; i < NrClusters; i++) begin
            cluster_axi_req_o[i]          = '0;
            cluster_axi_req_o[i].ar       = axi_req_i.ar;
            cluster_axi_req_o[i].ar.size  = ClusterSize;
            cluster_axi_req_o[i].ar_valid = c_ar_valid[i];
            cluster_axi_req_o[i].aw       = axi_req_i.aw;
            cluster_axi_req_o[i].aw.size  = ClusterSize;
            cluster_axi_req_o[i].aw_valid = c_aw_valid[i];
            cluster_axi_req_o[i].w.data   = axi_req_i.w.data[i*CW +: CW];
            cluster_axi_req_o[i].w.strb   = axi_req_i.w.strb[i*CS +: CS];
            cluster_axi_req_o[i].w.last   = axi_req_i.w.last;
            cluster_axi_req_o[i].w.user   = axi_req_i.w.user;
            cluster_axi_req_o[i].w_valid  = c_w_valid[i];
            cluster_axi_req_o[i].b_ready  = ~b_mask_q[i];
            cluster_axi_req_o[i].r_ready  = r_load;
        end
    end

    // Hardware takes last from cluster 0; a disagreement means the clusters lost lock-step.
    a_last_agree: assert property (@(posedge clk_i) disable iff (!rst_ni) r_load |-> !last_mismatch)
        else $error("cluster r.last disagrees with cluster 0");

endmodule

// File: tb/tb_global_mem_responder_bridge.sv
// tb/tb_global_mem_responder_bridge.sv - directed self-checking bench for global_mem_responder_bridge
`timescale 1ns/1ps
module tb_global_mem_responder_bridge;
    import global_mem_responder_bridge_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    axi_req_t          req;
    axi_resp_t         resp;
    cluster_axi_req_t  creq  [4];
    cluster_axi_resp_t cresp [4];

    int n_tests = 0;
    int n_fail  = 0;
    int c_ar_hs [4] = '{0, 0, 0, 0};
    int c_r_hs  [4] = '{0, 0, 0, 0};
    int sys_ar_hs = 0, sys_r_hs = 0, r_last_hs = 0, sys_b_hs = 0, n0 = 0;
    bit done = 1'b0;

    global_mem_responder_bridge dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .axi_req_i          (req),
        .axi_resp_o         (resp),
        .cluster_axi_req_o  (creq),
        .cluster_axi_resp_i (cresp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (creq[k].ar_valid && cresp[k].ar_ready) c_ar_hs[k]++;
            if (cresp[k].r_valid && creq[k].r_ready)   c_r_hs[k]++;
        end
        if (req.ar_valid && resp.ar_ready) sys_ar_hs++;
        if (resp.r_valid && req.r_ready) begin
            sys_r_hs++;
            if (resp.r.last) r_last_hs++;
        end
        if (resp.b_valid && req.b_ready) sys_b_hs++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic settle(); #1; endtask

    function automatic logic [63:0] cd(input int c, input int b);
        cd = {4'(10 + c), 52'h0, 8'(b)};
    endfunction

    function automatic logic [255:0] wd(input int b);
        wd = {cd(3, b), cd(2, b), cd(1, b), cd(0, b)};
    endfunction

    task automatic drive_r(input int b, input logic last, input logic [3:0] vmask, input logic [1:0] r3resp);
        for (int k = 0; k < 4; k++) begin
            cresp[k].r_valid = vmask[k];
            cresp[k].r.data  = cd(k, b);
            cresp[k].r.last  = last;
            cresp[k].r.id    = (k == 0) ? 4'd7 : 4'(k);
            cresp[k].r.user  = (k == 0) ? 1'b1 : 1'b0;
            cresp[k].r.resp  = (k == 3) ? r3resp : 2'd0;
        end
    endtask

    initial begin
        #100000;
        if (!done) begin
            n_fail++;
            $error("FAIL timeout: directed sequence did not complete");
            $finish;
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        for (int k = 0; k < 4; k++) cresp[k] = '0;
        tick();
        check("rst_ar_ready", resp.ar_ready, 1'b0);
        check("rst_w_ready", resp.w_ready, 1'b0);
        check("rst_r_valid", resp.r_valid, 1'b0);
        check("rst_b_valid", resp.b_valid, 1'b0);
        check("rst_c_ar_valid", creq[0].ar_valid, 1'b0);
        check("rst_c_r_ready", creq[0].r_ready, 1'b0);
        tick();
        rst_n = 1'b1;

        tick();
        req.ar.id = 4'd5; req.ar.addr = 64'h1000; req.ar.len = 8'd3; req.ar.size = 3'd5; req.ar.burst = 2'd1;
        req.ar_valid = 1'b1;
        for (int k = 0; k < 3; k++) cresp[k].ar_ready = 1'b1;
        settle();
        check("ar_c3_valid", creq[3].ar_valid, 1'b1);
        check("ar_size", creq[1].ar.size, 3'd3);
        check("ar_len", creq[2].ar.len, 8'd3);
        check("ar_addr", creq[3].ar.addr, 64'h1000);
        check("ar_ready_cyc0", resp.ar_ready, 1'b0);
        tick();
        check("ar_c0_masked", creq[0].ar_valid, 1'b0);
        check("ar_c3_held", creq[3].ar_valid, 1'b1);
        check("ar_ready_cyc1", resp.ar_ready, 1'b0);
        tick();
        cresp[3].ar_ready = 1'b1;
        settle();
        check("ar_ready_cyc2", resp.ar_ready, 1'b1);
        tick();
        req.ar_valid = 1'b0;
        for (int k = 0; k < 4; k++) check("ar_cluster_hs_count", c_ar_hs[k], 1);
        check("ar_sys_hs_count", sys_ar_hs, 1);

        req.r_ready = 1'b1;
        drive_r(0, 1'b0, 4'hF, 2'd0);
        settle();
        check("r_pop_c0", creq[0].r_ready, 1'b1);
        tick();
        check("r0_valid", resp.r_valid, 1'b1);
        check("r0_data", resp.r.data, wd(0));
        check("r0_last", resp.r.last, 1'b0);
        check("r0_id", resp.r.id, 4'd7);
        check("r0_user", resp.r.user, 1'b1);
        drive_r(1, 1'b0, 4'hF, 2'd2);
        tick();
        check("r1_data", resp.r.data, wd(1));
        check("r1_resp_max", resp.r.resp, 2'd2);
        drive_r(2, 1'b0, 4'hF, 2'd0);
        tick();
        check("r2_data", resp.r.data, wd(2));
        check("r2_resp", resp.r.resp, 2'd0);
        drive_r(3, 1'b1, 4'b1011, 2'd0);
        settle();
        check("r3_partial_c0_not_popped", creq[0].r_ready, 1'b0);
        tick();
        check("r3_no_early_beat", resp.r_valid, 1'b0);
        drive_r(3, 1'b1, 4'hF, 2'd0);
        settle();
        check("r3_c2_popped", creq[2].r_ready, 1'b1);
        tick();
        check("r3_valid", resp.r_valid, 1'b1);
        check("r3_data", resp.r.data, wd(3));
        check("r3_last", resp.r.last, 1'b1);
        drive_r(0, 1'b0, 4'h0, 2'd0);
        tick();
        check("r_drained", resp.r_valid, 1'b0);
        check("r_sys_beats", sys_r_hs, 4);
        check("r_last_count", r_last_hs, 1);
        for (int k = 0; k < 4; k++) check("r_cluster_pops", c_r_hs[k], 4);

        req.r_ready = 1'b0;
        drive_r(5, 1'b0, 4'hF, 2'd0);
        tick();
        check("rbp_loaded", resp.r.data, wd(5));
        drive_r(6, 1'b1, 4'hF, 2'd0);
        settle();
        check("rbp_c0_ready0", creq[0].r_ready, 1'b0);
        check("rbp_c3_ready0", creq[3].r_ready, 1'b0);
        tick();
        check("rbp_hold1", resp.r.data, wd(5));
        check("rbp_c1_ready0", creq[1].r_ready, 1'b0);
        tick();
        check("rbp_hold2", resp.r.data, wd(5));
        check("rbp_valid_held", resp.r_valid, 1'b1);
        req.r_ready = 1'b1;
        settle();
        check("rbp_resume_pop", creq[0].r_ready, 1'b1);
        tick();
        check("rbp_next_data", resp.r.data, wd(6));
        check("rbp_next_last", resp.r.last, 1'b1);
        drive_r(0, 1'b0, 4'h0, 2'd0);
        tick();
        check("rbp_drained", resp.r_valid, 1'b0);
        check("rbp_sys_beats", sys_r_hs, 6);

        for (int k = 0; k < 4; k++) begin
            cresp[k].aw_ready = 1'b1;
            cresp[k].w_ready  = (k != 1);
        end
        req.aw.id = 4'd2; req.aw.addr = 64'h2000; req.aw.len = 8'd1; req.aw.size = 3'd5; req.aw.burst = 2'd1;
        req.aw_valid = 1'b1;
        req.w.data = wd(8); req.w.strb = 32'hFFFF_0000; req.w.last = 1'b0; req.w_valid = 1'b1;
        settle();
        check("aw_ready", resp.aw_ready, 1'b1);
        check("aw_size", creq[2].aw.size, 3'd3);
        check("w_before_aw", creq[0].w_valid, 1'b0);
        check("w_ready_before_aw", resp.w_ready, 1'b0);
        tick();
        req.aw_valid = 1'b0;
        settle();
        check("w_strb_c0", creq[0].w.strb, 8'h00);
        check("w_strb_c1", creq[1].w.strb, 8'h00);
        check("w_strb_c2", creq[2].w.strb, 8'hFF);
        check("w_strb_c3", creq[3].w.strb, 8'hFF);
        check("w_data_c2", creq[2].w.data, cd(2, 8));
        check("w_stall0", resp.w_ready, 1'b0);
        tick();
        check("w_c0_masked", creq[0].w_valid, 1'b0);
        check("w_c1_pending", creq[1].w_valid, 1'b1);
        check("w_stall1", resp.w_ready, 1'b0);
        tick();
        cresp[1].w_ready = 1'b1;
        settle();
        check("w_ready_late2", resp.w_ready, 1'b1);
        tick();
        req.w.data = wd(9); req.w.last = 1'b1;
        settle();
        check("w1_c0_valid", creq[0].w_valid, 1'b1);
        check("w1_last", creq[3].w.last, 1'b1);
        check("w1_ready", resp.w_ready, 1'b1);
        tick();
        check("w_pending_zero", resp.w_ready, 1'b0);
        check("w_blocked_after", creq[0].w_valid, 1'b0);
        req.w_valid = 1'b0;

        req.aw_valid = 1'b1;
        repeat (4) tick();
        check("aw_full_ready", resp.aw_ready, 1'b0);
        check("aw_full_cvalid", creq[0].aw_valid, 1'b0);
        req.aw_valid = 1'b0;
        req.w_valid = 1'b1; req.w.last = 1'b1;
        tick();
        check("aw_unfull_ready", resp.aw_ready, 1'b1);
        repeat (3) tick();
        check("aw_drained_w_ready", resp.w_ready, 1'b0);
        req.w_valid = 1'b0;

        for (int k = 0; k < 4; k++) cresp[k].b.id = (k == 0) ? 4'd9 : 4'(k);
        cresp[2].b_valid = 1'b1; cresp[2].b.resp = 2'd2;
        settle();
        check("b_c2_ready", creq[2].b_ready, 1'b1);
        tick();
        cresp[2].b_valid = 1'b0;
        settle();
        check("b_c2_masked", creq[2].b_ready, 1'b0);
        check("b_partial", resp.b_valid, 1'b0);
        cresp[0].b_valid = 1'b1; cresp[0].b.resp = 2'd0;
        tick();
        cresp[0].b_valid = 1'b0;
        cresp[1].b_valid = 1'b1; cresp[3].b_valid = 1'b1;
        tick();
        cresp[1].b_valid = 1'b0; cresp[3].b_valid = 1'b0;
        check("b_valid", resp.b_valid, 1'b1);
        check("b_resp", resp.b.resp, 2'd2);
        check("b_id", resp.b.id, 4'd9);
        tick();
        check("b_held", resp.b_valid, 1'b1);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        check("b_popped", resp.b_valid, 1'b0);
        check("b_sys_count", sys_b_hs, 1);
        check("b_mask_cleared", creq[2].b_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin cresp[k].b_valid = 1'b1; cresp[k].b.resp = 2'd0; end
        tick();
        for (int k = 0; k < 4; k++) cresp[k].b_valid = 1'b0;
        check("b2_valid", resp.b_valid, 1'b1);
        check("b2_resp_cleared", resp.b.resp, 2'd0);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        check("b2_popped", resp.b_valid, 1'b0);

        req.r_ready = 1'b0;
        drive_r(1, 1'b0, 4'hF, 2'd0);
        req.ar.addr = 64'h3000; req.ar_valid = 1'b1;
        cresp[3].ar_ready = 1'b0;
        tick();
        drive_r(0, 1'b0, 4'h0, 2'd0);
        check("rst_mid_r_valid", resp.r_valid, 1'b1);
        check("rst_mid_ar_masked", creq[0].ar_valid, 1'b0);
        rst_n = 1'b0;
        req.ar_valid = 1'b0;
        settle();
        check("rst_mid_r_cleared", resp.r_valid, 1'b0);
        check("rst_mid_c3_valid", creq[3].ar_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        n0 = sys_ar_hs;
        req.ar_valid = 1'b1;
        cresp[3].ar_ready = 1'b1;
        settle();
        check("post_rst_mask_clear", creq[0].ar_valid, 1'b1);
        check("post_rst_ar_ready", resp.ar_ready, 1'b1);
        tick();
        req.ar_valid = 1'b0;
        check("post_rst_ar_hs", sys_ar_hs, n0 + 1);
        req.r_ready = 1'b1;
        drive_r(4, 1'b1, 4'hF, 2'd0);
        tick();
        drive_r(0, 1'b0, 4'h0, 2'd0);
        check("post_rst_r_data", resp.r.data, wd(4));
        tick();

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
